fc_argmax: RTL and testbench

- Classification stage directly downstream of the fully-connected layer.
- Snapshots the ten signed class scores when the FC stage signals completion.
- Scans the scores sequentially, one compare per cycle, to find the winning digit.
- Presents the winning index and score with a one-cycle valid pulse to the top-level result logic.

---
 rtl/cnn_pkg.sv | 25 ++
 rtl/fc_argmax_rise_detect.sv | 25 ++
 rtl/fc_argmax.sv | 156 +++++++++++++++
 tb/tb_fc_argmax.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the classification stage that follows the FC layer.
// Scores are full-width signed values; indices cover all class positions.
package cnn_pkg;

    localparam int SCORE_WIDTH = 113;
    localparam int NUM_CLASSES = 10;
    localparam int IDX_WIDTH   = 4;

    typedef logic signed [SCORE_WIDTH-1:0] score_t;
    typedef logic        [IDX_WIDTH-1:0]   idx_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } argmax_state_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_CLASSES - 1);

    // Strict signed compare: a tie never displaces the earlier (lower) index.
    function automatic logic beats(input score_t cand, input score_t best);
        return cand > best;
    endfunction

endpackage

// File: rtl/fc_argmax_rise_detect.sv
// Registered rising-edge detector. The delay register's reset value is a parameter,
// so a level already high at reset release can be kept from looking like an edge.
module rise_detect #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o
);

    logic sig_q;

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= RESET_VAL;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/fc_argmax.sv
// Argmax over the ten FC class scores: snapshot on fc_done rising edge, then one
// signed compare per cycle, then a one-cycle valid pulse with the winning index/score.
module fc_argmax
    import cnn_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fc_done,
    input  logic signed [SCORE_WIDTH-1:0] prob_0,
    input  logic signed [SCORE_WIDTH-1:0] prob_1,
    input  logic signed [SCORE_WIDTH-1:0] prob_2,
    input  logic signed [SCORE_WIDTH-1:0] prob_3,
    input  logic signed [SCORE_WIDTH-1:0] prob_4,
    input  logic signed [SCORE_WIDTH-1:0] prob_5,
    input  logic signed [SCORE_WIDTH-1:0] prob_6,
    input  logic signed [SCORE_WIDTH-1:0] prob_7,
    input  logic signed [SCORE_WIDTH-1:0] prob_8,
    input  logic signed [SCORE_WIDTH-1:0] prob_9,
    output logic                          busy,
    output logic                          class_valid,
    output logic        [IDX_WIDTH-1:0]   class_idx,
    output logic signed [SCORE_WIDTH-1:0] max_score,
    output logic                          overrun
);

    argmax_state_t state_q, state_d;
    score_t        buf_q [NUM_CLASSES];
    score_t        prob_a [NUM_CLASSES];
    score_t        best_q, best_d;
    idx_t          best_idx_q, best_idx_d;
    idx_t          k_q, k_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    idx_t          class_idx_q, class_idx_d;
    score_t        max_score_q, max_score_d;
    logic          overrun_q, overrun_d;
    logic          start;
    logic          load;

    assign prob_a[0] = prob_0;
    assign prob_a[1] = prob_1;
    assign prob_a[2] = prob_2;
    assign prob_a[3] = prob_3;
    assign prob_a[4] = prob_4;
    assign prob_a[5] = prob_5;
    assign prob_a[6] = prob_6;
    assign prob_a[7] = prob_7;
    assign prob_a[8] = prob_8;
    assign prob_a[9] = prob_9;

    // Reset value 1: fc_done held high across reset release must not start a scan.
    rise_detect #(
        .RESET_VAL (1'b1)
    ) u_start_det (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (fc_done),
        .rise_o (start)
    );

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d     = state_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        k_d         = k_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        class_idx_d = class_idx_q;
        max_score_d = max_score_q;
        overrun_d   = overrun_q;
        load        = 1'b0;

        if (start && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    best_d     = prob_a[0];
                    best_idx_d = '0;
                    k_d        = idx_t'(1);
                    busy_d     = 1'b1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (beats(buf_q[k_q], best_q)) begin
                    best_d     = buf_q[k_q];
                    best_idx_d = k_q;
                end
                k_d = k_q + idx_t'(1);
                if (k_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                class_idx_d = best_idx_q;
                max_score_d = best_q;
                valid_d     = 1'b1;
                busy_d      = 1'b0;
                k_d         = '0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            best_q      <= '0;
            best_idx_q  <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            class_idx_q <= '0;
            max_score_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            class_idx_q <= class_idx_d;
            max_score_q <= max_score_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: the snapshot buffer is cleared on reset so no stale scores outlive an abort.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                buf_q[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                buf_q[i] <= prob_a[i];
            end
        end
    end

    assign busy        = busy_q;
    assign class_valid = valid_q;
    assign class_idx   = class_idx_q;
    assign max_score   = max_score_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed bench for fc_argmax: expectations are queued when a start is driven and
// compared (index, score, arrival cycle) whenever class_valid is seen.
module tb_fc_argmax;
    import cnn_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   fc_done = 1'b0;
    score_t probs [NUM_CLASSES];
    logic   busy;
    logic   class_valid;
    idx_t   class_idx;
    score_t max_score;
    logic   overrun;

    typedef struct {
        idx_t   idx;
        score_t score;
        int     due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    fc_argmax dut (
        .clk         (clk),
        .rst         (rst),
        .fc_done     (fc_done),
        .prob_0      (probs[0]),
        .prob_1      (probs[1]),
        .prob_2      (probs[2]),
        .prob_3      (probs[3]),
        .prob_4      (probs[4]),
        .prob_5      (probs[5]),
        .prob_6      (probs[6]),
        .prob_7      (probs[7]),
        .prob_8      (probs[8]),
        .prob_9      (probs[9]),
        .busy        (busy),
        .class_valid (class_valid),
        .class_idx   (class_idx),
        .max_score   (max_score),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input int due);
        exp_t e;
        e.idx   = '0;
        e.score = probs[0];
        for (int k = 1; k < NUM_CLASSES; k++) begin
            if (probs[k] > e.score) begin
                e.score = probs[k];
                e.idx   = idx_t'(k);
            end
        end
        e.due = due;
        return e;
    endfunction

    // Scoreboard side: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (class_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", class_valid, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("valid_cycle", cyc, e.due);
                check("class_idx", class_idx, e.idx);
                check("max_score", max_score, e.score);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Raise fc_done just after a falling edge; the start edge is the next rising edge,
    // and the result is due at the falling edge after ten further rising edges.
    task automatic fire();
        fc_done = 1'b1;
        sb.push_back(model(cyc + 11));
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check({"drain_", tag}, sb.size(), 0);
    endtask

    task automatic set_all(input score_t v);
        for (int k = 0; k < NUM_CLASSES; k++) probs[k] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_all('0);
        #1 rst = 1'b0;
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", class_valid, 1'b0);
        check("rst_idx", class_idx, 4'd0);
        check("rst_score", max_score, '0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b1;
        tick();
        tick();

        // Basic scan: ascending scores, fc_done held for five cycles.
        for (int k = 0; k < NUM_CLASSES; k++) probs[k] = score_t'(k * 100);
        fire();
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) fc_done = 1'b0;
            check("basic_busy_hi", busy, 1'b1);
        end
        tick();
        check("basic_busy_lo", busy, 1'b0);
        drain("basic");
        tick();
        tick();
        check("hold_valid", class_valid, 1'b0);
        check("hold_idx", class_idx, 4'd9);
        check("hold_score", max_score, score_t'(900));

        // Negative scores with a tie at indices 3 and 7.
        set_all(score_t'(-5));
        probs[3] = score_t'(-1);
        probs[7] = score_t'(-1);
        fire();
        tick();
        fc_done = 1'b0;
        drain("tie");
        check("tie_idx", class_idx, 4'd3);
        check("tie_score", max_score, score_t'(-1));

        // Full-width extremes.
        set_all('0);
        probs[0] = {1'b1, {(SCORE_WIDTH-1){1'b0}}};
        probs[4] = {1'b0, {(SCORE_WIDTH-1){1'b1}}};
        fire();
        tick();
        fc_done = 1'b0;
        drain("extreme");
        check("ext_idx", class_idx, 4'd4);
        check("ext_score", max_score, {1'b0, {(SCORE_WIDTH-1){1'b1}}});
        check("ext_no_overrun", overrun, 1'b0);

        // Snapshot isolation plus a second edge three cycles into the scan.
        for (int k = 0; k < NUM_CLASSES; k++) probs[k] = score_t'(1000 - k * 7);
        fire();
        tick();
        fc_done = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) probs[k] = score_t'(k * 1000);
        tick();
        tick();
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        drain("isolation");
        repeat (15) tick();
        check("iso_overrun", overrun, 1'b1);
        check("iso_idx", class_idx, 4'd0);
        set_all('0);
        probs[5] = score_t'(77);
        fire();
        tick();
        fc_done = 1'b0;
        drain("after_overrun");
        check("overrun_sticky", overrun, 1'b1);

        // Asynchronous reset in the middle of a scan.
        set_all('0);
        probs[6] = score_t'(123);
        fc_done = 1'b1;
        tick();
        fc_done = 1'b0;
        repeat (3) tick();
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_valid", class_valid, 1'b0);
        check("arst_idx", class_idx, 4'd0);
        check("arst_score", max_score, '0);
        check("arst_overrun", overrun, 1'b0);
        fc_done = 1'b1;
        tick();
        rst = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            check("held_no_start", busy, 1'b0);
        end
        fc_done = 1'b0;
        tick();
        fire();
        tick();
        fc_done = 1'b0;
        drain("post_reset");
        check("post_reset_idx", class_idx, 4'd6);

        // Back-to-back starts exactly eleven cycles apart.
        set_all(score_t'(-3));
        probs[2] = score_t'(50);
        fire();
        tick();
        fc_done = 1'b0;
        set_all(score_t'(-3));
        probs[8] = score_t'(60);
        repeat (10) tick();
        fire();
        tick();
        fc_done = 1'b0;
        drain("b2b");
        check("b2b_idx", class_idx, 4'd8);
        check("b2b_overrun", overrun, 1'b0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
